// File: rtl/barrel_shift_pipe_pkg.sv
// rtl/barrel_shift_pipe_pkg.sv - shift mode encodings shared by the pipelined barrel shifter
//
// Package barrel_pkg
//   mode_t : 2-bit shift mode (MODE_LSL, MODE_LSR, MODE_ASR, MODE_ROL)
package barrel_pkg;

    typedef enum logic [1:0] {
        MODE_LSL = 2'd0,
        MODE_LSR = 2'd1,
        MODE_ASR = 2'd2,
        MODE_ROL = 2'd3
    } mode_t;

endpackage

// File: rtl/barrel_shift_pipe_if.sv
// rtl/barrel_shift_pipe_if.sv - operand/result handshake bundle for barrel_shift_pipe
//
// Signals
//   in_valid, in_ready, A, S, MODE : operand side (producer -> shifter)
//   out_valid, out_ready, Y, ZERO  : result side (shifter -> consumer)
// Modports
//   master : producer/consumer view (drives operands and out_ready)
//   slave  : shifter view
interface barrel_shift_pipe_if #(
    parameter int WIDTH = 8
);
    import barrel_pkg::*;

    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [SHW-1:0]   S;
    mode_t            MODE;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Y;
    logic             ZERO;

    modport master (
        output in_valid, A, S, MODE, out_ready,
        input  in_ready, out_valid, Y, ZERO
    );

    modport slave (
        input  in_valid, A, S, MODE, out_ready,
        output in_ready, out_valid, Y, ZERO
    );

endinterface

// File: rtl/barrel_shift_pipe_stage.sv
// rtl/barrel_shift_pipe_stage.sv - combinational shift by 2^K under a shift mode, gated by one shift bit
//
// Ports
//   d_i    : data entering the stage
//   mode_i : shift mode carried with the operand
//   sbit_i : shift-amount bit K; 0 passes data through
//   d_o    : stage result
module barrel_shift_stage
    import barrel_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K     = 0
) (
    input  logic [WIDTH-1:0] d_i,
    input  mode_t            mode_i,
    input  logic             sbit_i,
    output logic [WIDTH-1:0] d_o
);

    localparam int N = 1 << K;

    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = d_i;
        case (mode_i)
            MODE_LSL: shifted = d_i << N;
            MODE_LSR: shifted = d_i >> N;
            // MSB is preserved by an arithmetic shift, so later stages still
            // see the original operand sign.
            MODE_ASR: shifted = $signed(d_i) >>> N;
            default:  shifted = (d_i << N) | (d_i >> (WIDTH - N));
        endcase
        d_o = sbit_i ? shifted : d_i;
    end

endmodule

// File: rtl/barrel_shift_pipe.sv
// rtl/barrel_shift_pipe.sv - pipelined four-mode barrel shifter, one register stage per shift bit
//
// Ports
//   CLK   : rising-edge clock
//   RST_N : synchronous active-low reset
//   bus   : barrel_shift_pipe_if.slave (operand in, result out, valid/ready both sides)
module barrel_shift_pipe
    import barrel_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input logic                CLK,
    input logic                RST_N,
    barrel_shift_pipe_if.slave bus
);

    // Whole pipe advances in lock step; a stalled result freezes every stage.
    logic en;

    logic [WIDTH-1:0] data_q  [SHW];
    logic [SHW-1:0]   s_q     [SHW];
    mode_t            mode_q  [SHW];
    logic [SHW-1:0]   valid_q;
    logic             zero_q;

    logic [WIDTH-1:0] data_d  [SHW];

    assign en           = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        mode_t            m_in;
        logic             s_bit;

        if (k == 0) begin : g_head
            assign d_in  = bus.A;
            assign m_in  = bus.MODE;
            assign s_bit = bus.S[0];
        end else begin : g_body
            assign d_in  = data_q[k-1];
            assign m_in  = mode_q[k-1];
            assign s_bit = s_q[k-1][k];
        end

        barrel_shift_stage #(
            .WIDTH (WIDTH),
            .K     (k)
        ) u_stage (
            .d_i    (d_in),
            .mode_i (m_in),
            .sbit_i (s_bit),
            .d_o    (data_d[k])
        );
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= '0;
                s_q[k]    <= '0;
                mode_q[k] <= MODE_LSL;
            end
            valid_q <= '0;
            zero_q  <= 1'b0;
        end else if (en) begin
            // in_ready equals en, so in_valid alone qualifies the capture here.
            valid_q[0] <= bus.in_valid;
            s_q[0]     <= bus.S;
            mode_q[0]  <= bus.MODE;
            for (int k = 1; k < SHW; k++) begin
                valid_q[k] <= valid_q[k-1];
                s_q[k]     <= s_q[k-1];
                mode_q[k]  <= mode_q[k-1];
            end
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= data_d[k];
            end
            zero_q <= (data_d[SHW-1] == '0);
        end
    end

    assign bus.out_valid = valid_q[SHW-1];
    assign bus.Y         = data_q[SHW-1];
    assign bus.ZERO      = zero_q;

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb/tb_barrel_shift_pipe.sv - scoreboard bench for barrel_shift_pipe at WIDTH=8 and WIDTH=16
module tb_barrel_shift_pipe;
    import barrel_pkg::*;

    typedef struct {
        logic [63:0] y;
        logic        z;
        int          acc;
        bit          lat;
    } exp_t;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    barrel_shift_pipe_if #(.WIDTH(8))  b8  ();
    barrel_shift_pipe_if #(.WIDTH(16)) b16 ();

    barrel_shift_pipe #(.WIDTH(8))  dut8  (.CLK(CLK), .RST_N(RST_N), .bus(b8));
    barrel_shift_pipe #(.WIDTH(16)) dut16 (.CLK(CLK), .RST_N(RST_N), .bus(b16));

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t q8[$];
    exp_t q16[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: treats the operand as a w-bit number and applies the whole shift at once.
    function automatic logic [63:0] model(input int w, input longint a, input int s, input mode_t m);
        longint modv = longint'(1) << w;
        longint p    = longint'(1) << s;
        longint sv;
        longint r;
        case (m)
            MODE_LSL: r = (a * p) % modv;
            MODE_LSR: r = a / p;
            MODE_ASR: begin
                sv = (a >= modv / 2) ? a - modv : a;
                r  = (sv >>> s) & (modv - 1);
            end
            default:  r = ((a * p) % modv) + a / (modv / p);
        endcase
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send8(input logic [7:0] a, input int s, input mode_t m, input bit lat);
        bit   acc   = 0;
        int   guard = 0;
        exp_t e;
        b8.A = a; b8.S = 3'(s); b8.MODE = m; b8.in_valid = 1'b1;
        while (!acc) begin
            @(negedge CLK);
            acc = b8.in_ready;
            @(posedge CLK); #1;
            if (acc) begin
                e.y = model(8, longint'(a), s, m); e.z = (e.y == 0); e.acc = cyc; e.lat = lat;
                q8.push_back(e);
            end
            guard++;
            if (!acc && guard > 200) begin
                n_vec++; n_err++;
                $display("FAIL send8_timeout: in_ready stuck at 0, expected 1 within 200 cycles");
                acc = 1;
            end
        end
        b8.in_valid = 1'b0;
    endtask

    task automatic send16(input logic [15:0] a, input int s, input mode_t m, input bit lat);
        bit   acc   = 0;
        int   guard = 0;
        exp_t e;
        b16.A = a; b16.S = 4'(s); b16.MODE = m; b16.in_valid = 1'b1;
        while (!acc) begin
            @(negedge CLK);
            acc = b16.in_ready;
            @(posedge CLK); #1;
            if (acc) begin
                e.y = model(16, longint'(a), s, m); e.z = (e.y == 0); e.acc = cyc; e.lat = lat;
                q16.push_back(e);
            end
            guard++;
            if (!acc && guard > 200) begin
                n_vec++; n_err++;
                $display("FAIL send16_timeout: in_ready stuck at 0, expected 1 within 200 cycles");
                acc = 1;
            end
        end
        b16.in_valid = 1'b0;
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (RST_N) begin
            check("in_ready8", b8.in_ready, !b8.out_valid || b8.out_ready);
            if (b8.out_valid && b8.out_ready) begin
                if (q8.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected8: got Y=%0h, expected no result", b8.Y);
                end else begin
                    e = q8.pop_front();
                    check("Y8", b8.Y, e.y);
                    check("ZERO8", b8.ZERO, e.z);
                    if (e.lat) check("latency8", cyc - e.acc, 2);
                end
            end
        end
    end

    always @(negedge CLK) begin
        exp_t e;
        if (RST_N) begin
            if (b16.out_valid && b16.out_ready) begin
                if (q16.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected16: got Y=%0h, expected no result", b16.Y);
                end else begin
                    e = q16.pop_front();
                    check("Y16", b16.Y, e.y);
                    check("ZERO16", b16.ZERO, e.z);
                    if (e.lat) check("latency16", cyc - e.acc, 3);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit stop;
        b8.in_valid  = 0; b8.A  = '0; b8.S  = '0; b8.MODE  = MODE_LSL; b8.out_ready  = 1;
        b16.in_valid = 0; b16.A = '0; b16.S = '0; b16.MODE = MODE_LSL; b16.out_ready = 1;
        RST_N = 0;
        idle(2);
        check("rst_out_valid", b8.out_valid, 0);
        check("rst_Y", b8.Y, 0);
        check("rst_ZERO", b8.ZERO, 0);
        check("rst_in_ready", b8.in_ready, 1);
        check("rst_out_valid16", b16.out_valid, 0);
        RST_N = 1;

        send8(8'b11000111, 3, MODE_LSL, 1);
        idle(5);
        send8(8'b11000111, 2, MODE_LSR, 1);
        send8(8'b11000111, 1, MODE_ASR, 1);
        send8(8'b11000111, 3, MODE_ROL, 1);
        idle(5);

        send8(8'h80, 7, MODE_ASR, 1);
        send8(8'h80, 7, MODE_LSR, 1);
        send8(8'h01, 7, MODE_LSL, 1);
        send8(8'h01, 0, MODE_ROL, 1);
        send8(8'hF0, 4, MODE_LSL, 1);
        for (int m = 0; m < 4; m++) send8(8'($urandom), 0, mode_t'(m), 1);
        idle(5);

        // Backpressure: fill the pipe while the consumer stalls.
        b8.out_ready = 0;
        for (int i = 0; i < 3; i++) send8(8'($urandom), $urandom_range(0, 7), mode_t'($urandom_range(0, 3)), 0);
        repeat (2) begin
            @(negedge CLK);
            check("bp_in_ready", b8.in_ready, 0);
            check("bp_out_valid", b8.out_valid, 1);
            check("bp_hold_Y", b8.Y, q8[0].y);
        end
        @(posedge CLK); #1;
        b8.out_ready = 1;
        idle(6);
        check("bp_drained", q8.size(), 0);

        // Reset with two operations in flight.
        send8(8'h5A, 1, MODE_LSL, 1);
        send8(8'hA5, 2, MODE_ROL, 1);
        RST_N = 0;
        q8.delete();
        idle(1);
        check("rst_mid_out_valid", b8.out_valid, 0);
        check("rst_mid_Y", b8.Y, 0);
        check("rst_mid_in_ready", b8.in_ready, 1);
        RST_N = 1;
        repeat (5) begin
            @(negedge CLK);
            check("rst_no_stale", b8.out_valid, 0);
        end
        idle(1);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send8(8'($urandom), $urandom_range(0, 7), mode_t'($urandom_range(0, 3)), 1);
        end
        idle(5);

        stop = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) idle(1);
                    send8(8'($urandom), $urandom_range(0, 7), mode_t'($urandom_range(0, 3)), 0);
                end
                stop = 1;
            end
            begin
                while (!stop) begin
                    @(posedge CLK); #1;
                    b8.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        b8.out_ready = 1;
        idle(8);
        check("rand_drained8", q8.size(), 0);

        send16(16'h8001, 15, MODE_ROL, 1);
        send16(16'h8000, 15, MODE_ASR, 1);
        for (int i = 0; i < 40; i++) begin
            send16(16'($urandom), $urandom_range(0, 15), mode_t'($urandom_range(0, 3)), 1);
        end
        idle(8);
        check("rand_drained16", q16.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
